// File: rtl/limb_pkg.sv
// Shared types and instruction-field layout for the Limb CPU control path.
// Instruction word: [29:27] class, [26:24] op/cond, [23:20] dst, [19:16] src A, [15:12] src B, [7:0] imm.
package limb_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU_REG = 3'd0,
    CL_ALU_IMM = 3'd1,
    CL_LOAD    = 3'd2,
    CL_STORE   = 3'd3,
    CL_BRANCH  = 3'd4,
    CL_CALL    = 3'd5,
    CL_RET     = 3'd6,
    CL_HALT    = 3'd7
  } class_e;

  typedef enum logic [2:0] {
    CD_EQ     = 3'd0,
    CD_NE     = 3'd1,
    CD_LT     = 3'd2,
    CD_GT     = 3'd3,
    CD_LE     = 3'd4,
    CD_GE     = 3'd5,
    CD_ALWAYS = 3'd6,
    CD_NEVER  = 3'd7
  } cond_e;

  localparam logic [1:0] RF_SEL_ALU = 2'd0;
  localparam logic [1:0] RF_SEL_RAM = 2'd1;
  localparam logic [1:0] RF_SEL_RIO = 2'd2;

  localparam int IR_CLASS_LSB = 27;
  localparam int IR_OP_LSB    = 24;
  localparam int IR_DST_LSB   = 20;
  localparam int IR_SRCA_LSB  = 16;
  localparam int IR_SRCB_LSB  = 12;
  localparam int IR_IMM_LSB   = 0;

  function automatic class_e ir_class(input logic [31:0] ir);
    return class_e'(ir[IR_CLASS_LSB +: 3]);
  endfunction

  function automatic cond_e ir_cond(input logic [31:0] ir);
    return cond_e'(ir[IR_OP_LSB +: 3]);
  endfunction

endpackage

// File: rtl/limb_cond_eval.sv
// Branch/call condition evaluation from the ALU's unsigned rs1-vs-rs2 compare flags.
module limb_cond_eval
  import limb_pkg::*;
(
  input  cond_e cond,
  input  logic  alu_eq,
  input  logic  alu_lt,
  input  logic  alu_gt,
  output logic  taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      CD_EQ:     taken = alu_eq;
      CD_NE:     taken = !alu_eq;
      CD_LT:     taken = alu_lt;
      CD_GT:     taken = alu_gt;
      CD_LE:     taken = alu_lt | alu_eq;
      CD_GE:     taken = alu_gt | alu_eq;
      CD_ALWAYS: taken = 1'b1;
      CD_NEVER:  taken = 1'b0;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/limb_sequencer.sv
// Limb CPU control unit: owns pc, ir, call depth and the FETCH/EXEC/MEM/WB/HALT machine.
// Strobes are decoded from state and ir and are all forced low while run is 0.
module limb_sequencer
  import limb_pkg::*;
#(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter int         STACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic [3:0]  rf_src_a,
  output logic [3:0]  rf_src_b,
  output logic [3:0]  rf_dst,
  output logic        rf_we,
  output logic [1:0]  rf_sel,
  output logic [2:0]  alu_op,
  output logic        alu_b_imm,
  output logic [7:0]  imm,
  input  logic        alu_eq,
  input  logic        alu_lt,
  input  logic        alu_gt,
  output logic        ram_we,
  output logic        stk_push,
  output logic        stk_pop,
  output logic [7:0]  stk_wdata,
  input  logic [7:0]  stk_rdata,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state_dbg
);

  localparam logic [7:0] MAX_DEPTH = 8'(STACK_DEPTH);

  state_e      state_q;
  logic [7:0]  pc_q;
  logic [31:0] ir_q;
  logic [7:0]  depth_q;
  logic        fault_q;

  class_e     cls;
  cond_e      cond;
  logic [7:0] pc_inc;
  logic       taken;
  logic       can_push;
  logic       can_pop;
  logic       in_exec;
  logic       unused_ir;

  assign cls       = ir_class(ir_q);
  assign cond      = ir_cond(ir_q);
  assign pc_inc    = pc_q + 8'd1;
  assign can_push  = depth_q < MAX_DEPTH;
  assign can_pop   = depth_q != 8'd0;
  assign in_exec   = run && (state_q == ST_EXEC);
  assign unused_ir = ^{ir_q[31:30], ir_q[11:8]};

  limb_cond_eval u_cond (
    .cond   (cond),
    .alu_eq (alu_eq),
    .alu_lt (alu_lt),
    .alu_gt (alu_gt),
    .taken  (taken)
  );

  // Field decode is passed straight through; the datapath uses it only when a strobe fires.
  assign rom_addr  = pc_q;
  assign rf_src_a  = ir_q[IR_SRCA_LSB +: 4];
  assign rf_src_b  = ir_q[IR_SRCB_LSB +: 4];
  assign rf_dst    = ir_q[IR_DST_LSB +: 4];
  assign alu_op    = ir_q[IR_OP_LSB +: 3];
  assign imm       = ir_q[IR_IMM_LSB +: 8];
  assign alu_b_imm = (cls == CL_ALU_IMM);
  assign rf_sel    = (cls == CL_LOAD) ? RF_SEL_RAM : RF_SEL_ALU;
  assign stk_wdata = pc_inc;

  assign rf_we     = run && (state_q == ST_WB);
  assign ram_we    = in_exec && (cls == CL_STORE);
  assign stk_push  = in_exec && (cls == CL_CALL) && taken && can_push;
  assign stk_pop   = in_exec && (cls == CL_RET) && can_pop;

  assign halted    = (state_q == ST_HALT);
  assign fault     = fault_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      depth_q <= '0;
      fault_q <= 1'b0;
    end else if (run) begin
      case (state_q)
        ST_FETCH: begin
          ir_q    <= rom_data;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          case (cls)
            CL_ALU_REG, CL_ALU_IMM: state_q <= ST_WB;
            CL_LOAD:                state_q <= ST_MEM;
            CL_STORE: begin
              pc_q    <= pc_inc;
              state_q <= ST_FETCH;
            end
            CL_BRANCH: begin
              pc_q    <= taken ? imm : pc_inc;
              state_q <= ST_FETCH;
            end
            CL_CALL: begin
              if (!taken) begin
                pc_q    <= pc_inc;
                state_q <= ST_FETCH;
              end else if (can_push) begin
                depth_q <= depth_q + 8'd1;
                pc_q    <= imm;
                state_q <= ST_FETCH;
              end else begin
                fault_q <= 1'b1;
                state_q <= ST_HALT;
              end
            end
            CL_RET: begin
              if (can_pop) begin
                depth_q <= depth_q - 8'd1;
                pc_q    <= stk_rdata;
                state_q <= ST_FETCH;
              end else begin
                fault_q <= 1'b1;
                state_q <= ST_HALT;
              end
            end
            CL_HALT: state_q <= ST_HALT;
            default: state_q <= ST_HALT;
          endcase
        end
        ST_MEM: state_q <= ST_WB;
        ST_WB: begin
          pc_q    <= pc_inc;
          state_q <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: doc/limb_sequencer.md
Name: limb_sequencer

Overview:
- Multi-cycle control unit for the Limb 8-bit CPU.
- Owns pc, ir and the control state machine. Drives ROM address, register-file, ALU, RAM and call-stack control signals.
- Resolves branches, calls and returns, and tracks call-stack depth so overflow and underflow halt the core cleanly.
- Sits between the program ROM and the datapath modules in the top level.

Parameters:
- RESET_PC, 8'h00, pc value loaded on reset.
- STACK_DEPTH, 16, maximum call depth; range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  0 holds the FSM in its current state with no side effects
- rom_addr  out  8  ROM address; equals pc
- rom_data  in  32  instruction word
- rf_src_a  out  4  register-file read port A select (ir[19:16])
- rf_src_b  out  4  register-file read port B select (ir[15:12])
- rf_dst  out  4  register-file write select (ir[23:20])
- rf_we  out  1  register-file write strobe
- rf_sel  out  2  write-data mux: 0 ALU, 1 RAM, 2 rio_in
- alu_op  out  3  ALU operation (ir[26:24])
- alu_b_imm  out  1  1 selects imm as ALU operand B
- imm  out  8  ir[7:0]
- alu_eq / alu_lt / alu_gt  in  1 each  unsigned compare of rs1 vs rs2
- ram_we  out  1  RAM write strobe (address r15, data rs2)
- stk_push / stk_pop  out  1 each  call-stack strobes
- stk_wdata  out  8  return address, pc+1 mod 256
- stk_rdata  in  8  popped return address
- halted  out  1  core stopped
- fault  out  1  sticky; stack overflow or underflow occurred
- state_dbg  out  3  current state encoding

Behaviour:
- Encoding: ir[29:27] class:
  - 0 ALU register
  - 1 ALU immediate
  - 2 LOAD
  - 3 STORE
  - 4 branch
  - 5 call
  - 6 RET
  - 7 HALT
- Condition field ir[26:24] for branch and call: 0 EQ, 1 NE, 2 LT, 3 GT, 4 LE, 5 GE, 6 always, 7 never.
- States: FETCH, EXEC, MEM, WB, HALT.
- Reset values: pc = RESET_PC, ir = 0, state = FETCH, depth = 0, fault = 0. All strobes are 0, halted = 0.
- FETCH: ir <= rom_data; go to EXEC.
- EXEC:
  - ALU classes: go to WB.
  - LOAD: go to MEM.
  - STORE: ram_we = 1 for one cycle; pc++; go to FETCH.
  - Branch taken: pc <= imm. Not taken: pc <= pc+1. Go to FETCH.
  - Call taken with depth < STACK_DEPTH: stk_push = 1, stk_wdata = pc+1, depth++, pc <= imm.
  - Call taken with depth == STACK_DEPTH: no push; fault = 1; go to HALT.
  - RET with depth > 0: stk_pop = 1, pc <= stk_rdata, depth--.
  - RET with depth == 0: fault = 1; go to HALT.
  - HALT: go to HALT.
- MEM: go to WB with rf_sel = 1.
- WB: rf_we = 1 for one cycle; pc++; go to FETCH.
  - rf_we is asserted even when rf_dst = 0; the register file ignores r0.
- Latency: ALU op 3 cycles; LOAD 4; STORE, branch, call and RET 2 each.
- pc arithmetic is modulo 256; pc = 8'hFF followed by increment gives 8'h00.
- Strobes are combinational from state and ir, and are gated by run.
- When run = 0, no register updates. Exception: reset still acts.
- HALT is terminal until reset; halted = 1; all strobes are 0.
- Reset asserted mid-instruction aborts the instruction with no strobe. The first post-reset cycle is FETCH at RESET_PC.
- Unknown class values: not possible with 3 bits; all 8 classes are defined.

Decomposition:
- Package limb_pkg holds:
  - state_e enum
  - class_e enum
  - cond_e enum
  - rf_sel constants
  - field-slice localparams for ir
- One sub-module, limb_cond_eval: combinational; takes cond and the three flags, returns taken.

Test Plan:
- Reset release, ROM[0] = ADDI r1, r0, 5 (class 1, op add, imm 5): FETCH, EXEC, WB. rf_we high in cycle 3 with rf_dst = 1, alu_b_imm = 1. pc = 1 after.
- LOAD r2 at pc 4: ram_we = 0 throughout; rf_sel = 1 and rf_we = 1 in cycle 4; pc = 5. STORE: ram_we high exactly one cycle.
- BEQ with alu_eq = 1, imm = 8'h40 at pc 3: pc = 8'h40 after 2 cycles. With alu_eq = 0: pc = 4.
- CALL imm = 8'h20 at pc 7: stk_push with stk_wdata = 8. Then RET with stk_rdata = 8: stk_pop asserted, pc = 8.
- STACK_DEPTH = 2, three nested calls: third call gives no push, fault = 1, halted = 1. RET at depth 0 gives the same fault.
- Branch-always at pc 8'hFF with imm 8'hFF: pc stays 8'hFF. Toggle run = 0 for 5 cycles mid-WB: state and pc are frozen and rf_we is deasserted. Reset asserted during EXEC of a call: no push, pc = 0.
